alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised, multi-cycle successor to the per-thread ALU; one instance per thread in each core.
- Adds configurable datapath width and a valid/ready handshake so the scheduler can stall on long operations.
- Replaces single-cycle multiply and divide with iterative shift-add multiply and restoring divide.
- Adds signed compare for NZP and a divide-by-zero flag.

Parameters:
- DATA_BITS, 8: operand and result width; legal range 4..32.
- CNT_BITS, $clog2(DATA_BITS+1): iteration counter width; derived, never overridden.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  request strobe
- op_ready  out  1  high when a request can be accepted
- op_code  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 CMP, 101 MOD (feature-gated), 11x reserved
- rs  in  DATA_BITS  operand A
- rt  in  DATA_BITS  operand B
- result  out  DATA_BITS  result, held stable until the next accept
- result_valid  out  1  one-cycle pulse when result is updated
- div_zero  out  1  set alongside result_valid when DIV/MOD had rt==0, else 0

Behaviour:
- Reset (async, any state, including mid-iteration): state=IDLE; op_ready=1; result=0; result_valid=0; div_zero=0; counter and internal registers cleared.
- Accept: a request is taken on a rising edge where op_valid&&op_ready. rs, rt and op_code are latched on that edge; inputs are ignored at all other times.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE: op_ready=1.
  - On accepting ADD/SUB/CMP/reserved: compute, go to DONE. result_valid rises the next edge (latency 1).
  - On accepting MUL: go to MUL_RUN. On accepting DIV/MOD: go to DIV_RUN. Counter=0 in both cases.
- MUL_RUN / DIV_RUN: op_ready=0. One iteration per cycle; exit to DONE when counter reaches DATA_BITS-1. Latency from accept to result_valid is DATA_BITS+1 cycles.
- DONE: result_valid=1 for exactly one cycle, op_ready=0, then return to IDLE. Back-to-back throughput is one op per 2 cycles minimum.
- ADD/SUB: modulo 2^DATA_BITS, wrap silently, no carry out.
- MUL: low DATA_BITS bits of the unsigned product. Shift-add, LSB-first on the multiplier.
- DIV: unsigned restoring division, one quotient bit per cycle, MSB first.
  - If rt==0: result=all ones, div_zero=1. Still takes the full DATA_BITS cycles so latency is constant.
- CMP: signed two's-complement compare of rs and rt. result = zero-extended {P,Z,N} in bits [2:0].
  - Exactly one bit set: P if rs>rt, Z if equal, N if rs<rt. Computed from a DATA_BITS+1 bit difference so overflow is handled.
- Reserved op_code: result=0, latency 1, no error flag.
- result and div_zero hold their values between pulses.
- op_valid asserted while op_ready=0: ignored, no queueing. The requester must hold op_valid until accepted.

Optional Feature:
- Macro: ALU_ITER_MOD_EN.
- Defined: op_code 101 runs through DIV_RUN and returns the remainder.
  - rt==0 gives result=rs and div_zero=1.
- Undefined: 101 is treated as reserved (result 0, latency 1). No remainder output logic is synthesised.

Test Plan:
- Reset mid-DIV (DATA_BITS=8, 200/7, reset asserted after 3 cycles) -> outputs zero immediately without waiting for a clock; op_ready=1; no result_valid afterwards.
- ADD 250+10 -> result=4, result_valid exactly 1 cycle after accept. Then SUB 3-5 -> result=0xFE.
- MUL 13*11 -> result=143, valid at accept+9. MUL 200*2 -> result=144 (truncated). op_ready=0 throughout the run.
- DIV 200/7 -> result=28, div_zero=0. DIV 5/0 -> result=0xFF, div_zero=1, valid at accept+9.
- CMP with (rs,rt) = (0x80,0x01), (0x05,0x05), (0x7F,0x80) -> result = 001 (N), 010 (Z), 100 (P).
- MOD 200%7 -> 4 when ALU_ITER_MOD_EN is defined, 0 at latency 1 otherwise. Repeat the run with DATA_BITS=16 (MUL 300*300 -> 0x5F90).

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU (add/sub/cmp, shift-add mul, restoring div) with valid/ready handshake.
// Define ALU_ITER_MOD_EN to enable the remainder op (op_code 101); otherwise 101 is reserved.
module alu_iter #(
    parameter int DATA_BITS = 8,
    parameter int CNT_BITS  = $clog2(DATA_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [2:0]           op_code,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic [DATA_BITS-1:0] result,
    output logic                 result_valid,
    output logic                 div_zero
);
    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [DATA_BITS-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [DATA_BITS-1:0] result_q, result_d;
    logic                 result_valid_q, result_valid_d, div_zero_q, div_zero_d;
    logic [DATA_BITS:0]   rem_sh, cmp_diff;
    logic [DATA_BITS-1:0] rem_sub, done_res;
    logic                 div_ge;
    logic [2:0]           pzn;

    function automatic logic is_div(input logic [2:0] op);
`ifdef ALU_ITER_MOD_EN
        return op == 3'b011 || op == 3'b101;
`else
        return op == 3'b011;
`endif
    endfunction

    // a_q shifts the dividend out MSB-first while quotient bits shift in; acc_q is the partial remainder
    assign rem_sh   = {acc_q, a_q[DATA_BITS-1]};
    assign div_ge   = rem_sh >= {1'b0, b_q};
    assign rem_sub  = DATA_BITS'(rem_sh - {1'b0, b_q});
    assign cmp_diff = {a_q[DATA_BITS-1], a_q} - {b_q[DATA_BITS-1], b_q};
    assign pzn      = cmp_diff == '0 ? 3'b010 : cmp_diff[DATA_BITS] ? 3'b001 : 3'b100;

    always_comb begin
        done_res = '0;
        case (op_q)
            3'b000:  done_res = a_q + b_q;
            3'b001:  done_res = a_q - b_q;
            3'b010:  done_res = acc_q;
            3'b011:  done_res = a_q;
            3'b100:  done_res = DATA_BITS'(pzn);
`ifdef ALU_ITER_MOD_EN
            3'b101:  done_res = acc_q;
`endif
            default: done_res = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        div_zero_d     = div_zero_q;
        case (state_q)
            IDLE: if (op_valid) begin
                op_d    = op_code;
                a_d     = rs;
                b_d     = rt;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = op_code == 3'b010 ? MUL_RUN : is_div(op_code) ? DIV_RUN : DONE;
            end
            MUL_RUN: begin
                acc_d   = acc_q + (b_q[0] ? a_q : '0);
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_BITS'(1);
                state_d = cnt_q == LAST ? DONE : MUL_RUN;
            end
            DIV_RUN: begin
                acc_d   = div_ge ? rem_sub : rem_sh[DATA_BITS-1:0];
                a_d     = {a_q[DATA_BITS-2:0], div_ge};
                cnt_d   = cnt_q + CNT_BITS'(1);
                state_d = cnt_q == LAST ? DONE : DIV_RUN;
            end
            default: begin
                result_d       = done_res;
                result_valid_d = 1'b1;
                div_zero_d     = is_div(op_q) && b_q == '0;
                state_d        = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            div_zero_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            div_zero_q     <= div_zero_d;
        end
    end

    assign op_ready     = state_q == IDLE;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign div_zero     = div_zero_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed checks of alu_iter at DATA_BITS=8 and DATA_BITS=16.
module tb_alu_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        sel = 1'b0;
    logic [2:0]  op_code = '0;
    logic [15:0] rs = '0, rt = '0;
    logic        rdy8, rv8, dz8, rdy16, rv16, dz16;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic        rdy_m, rv_m, dz_m;
    logic [15:0] res_m;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_iter #(.DATA_BITS(8)) u8 (
        .clk(clk), .reset(reset), .op_valid(op_valid && !sel), .op_ready(rdy8),
        .op_code(op_code), .rs(rs[7:0]), .rt(rt[7:0]),
        .result(res8), .result_valid(rv8), .div_zero(dz8)
    );

    alu_iter #(.DATA_BITS(16)) u16 (
        .clk(clk), .reset(reset), .op_valid(op_valid && sel), .op_ready(rdy16),
        .op_code(op_code), .rs(rs), .rt(rt),
        .result(res16), .result_valid(rv16), .div_zero(dz16)
    );

    assign rdy_m = sel ? rdy16 : rdy8;
    assign rv_m  = sel ? rv16 : rv8;
    assign dz_m  = sel ? dz16 : dz8;
    assign res_m = sel ? res16 : {8'h00, res8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input logic exp_dz, input int exp_lat);
        int   lat;
        logic rdy_busy;
        @(negedge clk);
        sel      = s;
        check({tag, "_ready"}, rdy_m, 1'b1);
        op_code  = op;
        rs       = a;
        rt       = b;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat      = 0;
        rdy_busy = 1'b0;
        while (!rv_m && lat < 40) begin
            if (rdy_m) rdy_busy = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_res"}, res_m, exp);
        check({tag, "_dz"}, dz_m, exp_dz);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, rdy_busy, 1'b0);
        @(posedge clk);
        #1 check({tag, "_pulse"}, rv_m, 1'b0);
        check({tag, "_hold"}, res_m, exp);
    endtask

    initial begin
        int seen;
        #12;
        check("rst_res", res8, 8'h00);
        check("rst_rv", rv8, 1'b0);
        check("rst_rdy", rdy8, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        // leave nonzero outputs behind so the async reset has something to clear
        run_op("div5_0", 1'b0, 3'b011, 16'd5, 16'd0, 16'h00FF, 1'b1, 9);
        @(negedge clk);
        sel = 1'b0; op_code = 3'b011; rs = 16'd200; rt = 16'd7; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_res", res8, 8'h00);
        check("mid_rst_dz", dz8, 1'b0);
        check("mid_rst_rv", rv8, 1'b0);
        check("mid_rst_rdy", rdy8, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (rv8) seen++;
        end
        check("mid_rst_no_rv", seen, 0);

        run_op("add", 1'b0, 3'b000, 16'd250, 16'd10, 16'd4, 1'b0, 1);
        run_op("sub", 1'b0, 3'b001, 16'd3, 16'd5, 16'h00FE, 1'b0, 1);
        run_op("mul13_11", 1'b0, 3'b010, 16'd13, 16'd11, 16'd143, 1'b0, 9);
        run_op("mul200_2", 1'b0, 3'b010, 16'd200, 16'd2, 16'd144, 1'b0, 9);
        run_op("div200_7", 1'b0, 3'b011, 16'd200, 16'd7, 16'd28, 1'b0, 9);
        run_op("div5_0b", 1'b0, 3'b011, 16'd5, 16'd0, 16'h00FF, 1'b1, 9);
        run_op("dz_clear", 1'b0, 3'b000, 16'd1, 16'd1, 16'd2, 1'b0, 1);
        run_op("cmp_n", 1'b0, 3'b100, 16'h0080, 16'h0001, 16'd1, 1'b0, 1);
        run_op("cmp_z", 1'b0, 3'b100, 16'h0005, 16'h0005, 16'd2, 1'b0, 1);
        run_op("cmp_p", 1'b0, 3'b100, 16'h007F, 16'h0080, 16'd4, 1'b0, 1);
        run_op("rsvd", 1'b0, 3'b110, 16'd9, 16'd3, 16'd0, 1'b0, 1);
`ifdef ALU_ITER_MOD_EN
        run_op("mod", 1'b0, 3'b101, 16'd200, 16'd7, 16'd4, 1'b0, 9);
        run_op("mod0", 1'b0, 3'b101, 16'd200, 16'd0, 16'd200, 1'b1, 9);
        run_op("mod16", 1'b1, 3'b101, 16'd1000, 16'd7, 16'd6, 1'b0, 17);
`else
        run_op("mod", 1'b0, 3'b101, 16'd200, 16'd7, 16'd0, 1'b0, 1);
        run_op("mod16", 1'b1, 3'b101, 16'd1000, 16'd7, 16'd0, 1'b0, 1);
`endif
        run_op("mul16", 1'b1, 3'b010, 16'd300, 16'd300, 16'h5F90, 1'b0, 17);
        run_op("div16", 1'b1, 3'b011, 16'd50000, 16'd123, 16'd406, 1'b0, 17);
        run_op("div16_0", 1'b1, 3'b011, 16'd1000, 16'd0, 16'hFFFF, 1'b1, 17);
        run_op("cmp16", 1'b1, 3'b100, 16'h8000, 16'h7FFF, 16'd1, 1'b0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
